// File: rtl/loop_nest_ctrl.sv
// loop_nest_ctrl
//   N-level nested-loop iterator. A configuration beat supplies a maximum
//   value per level. The block then emits one output beat per iteration of
//   the loop nest. Counting is odometer style and every level counts down:
//   level 0 is the innermost loop and changes fastest. Each level loads max,
//   counts down to 0, and then wraps back to max when the levels below it
//   roll over.
//
// Ports
//   clk        clock
//   rstn_g     asynchronous active-low global reset
//   cfg_valid  configuration beat valid
//   cfg_ready  configuration accepted (high only while idle)
//   cfg_max    per-level max; level k occupies [k*W +: W]
//   m_valid    output beat valid (high while running)
//   m_ready    downstream accepts the beat
//   m_count    per-level count, packed the same way as cfg_max
//   m_first    bit k set when count[k] == max[k]
//   m_last     bit k set when count[k] == 0
//   m_done     one-cycle pulse in the cycle after the final beat is accepted
//   busy       high while running
module loop_nest_ctrl #(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rstn_g,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [N*W-1:0] cfg_max,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N*W-1:0] m_count,
  output logic [N-1:0]   m_first,
  output logic [N-1:0]   m_last,
  output logic           m_done,
  output logic           busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [N-1:0][W-1:0]  cnt_q;
  logic [N-1:0][W-1:0]  max_q;
  logic [N-1:0][W-1:0]  cnt_nxt;
  logic [N-1:0]         lower_zero;
  logic                 accept;
  logic                 final_beat;

  // The handshake outputs are direct decodes of the state flop. m_valid
  // therefore never depends on m_ready in the same cycle.
  assign m_valid   = (state == RUN);
  assign busy      = (state == RUN);
  assign cfg_ready = (state == IDLE);
  assign m_count   = cnt_q;

  assign accept     = m_valid & m_ready;
  assign final_beat = &m_last;

  // Decode the per-level flags and compute the odometer step.
  // A level moves only when every level below it sits at 0. A level that
  // moves wraps to its max instead of underflowing, so max = 2^W-1 works.
  // NOTE: every signal is given a default at the top of always_comb so that
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    m_first    = '0;
    m_last     = '0;
    lower_zero = '0;
    cnt_nxt    = cnt_q;
    for (int k = 0; k < N; k++) begin
      m_first[k] = (cnt_q[k] == max_q[k]);
      m_last[k]  = (cnt_q[k] == '0);
    end
    lower_zero[0] = 1'b1;
    for (int k = 1; k < N; k++) begin
      lower_zero[k] = lower_zero[k-1] & m_last[k-1];
    end
    for (int k = 0; k < N; k++) begin
      if (lower_zero[k]) begin
        cnt_nxt[k] = m_last[k] ? max_q[k] : cnt_q[k] - W'(1);
      end
    end
  end

  // NOTE: the counter and max registers are asynchronously reset along with
  // the state. A reset in the middle of a job therefore leaves clean zeros,
  // not stale values.
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, no matter what order the statements are in.
  always_ff @(posedge clk or negedge rstn_g) begin
    if (!rstn_g) begin
      state  <= IDLE;
      cnt_q  <= '0;
      max_q  <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            max_q <= cfg_max;
            cnt_q <= cfg_max;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            // The final beat leaves the counts at zero rather than wrapping.
            if (final_beat) begin
              state  <= IDLE;
              m_done <= 1'b1;
            end else begin
              cnt_q <= cnt_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
